// File: rtl/onewire_slave.sv
// 1-wire slave endpoint: answers bus resets with presence and serves read slots LSB first.
// Optional ONEWIRE_SLAVE_REPEAT_EN: the loaded byte repeats until the next rst_ni.
module onewire_slave #(
  parameter int unsigned RST_MIN  = 32,
  parameter int unsigned PRES_DLY = 2,
  parameter int unsigned PRES_LEN = 24,
  parameter int unsigned BIT_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  inout  wire        port_io,
  input  logic [7:0] data_in_i,
  input  logic       load_i,
  output logic       ready_o,
  output logic       drive_o,
  output logic       online_o,
  output logic       done_o,
  output logic [2:0] bit_cnt_o
);

  localparam int unsigned LowW  = $clog2(RST_MIN + 1);
  localparam int unsigned HoldW = $clog2(BIT_HOLD + 1);
  localparam int unsigned TmrW  = 16;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StLow      = 3'd1;
  localparam logic [2:0] StPresWait = 3'd2;
  localparam logic [2:0] StPres     = 3'd3;
  localparam logic [2:0] StWaitHigh = 3'd4;

  logic [2:0]      state_q, state_d;
  logic            sync1_q, bus_s_q, prev_q;
  logic [LowW-1:0] lowcnt_q, lowcnt_d;
  logic [HoldW-1:0] hcnt_q, hcnt_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            drive_q, drive_d;
  logic            online_q, online_d;
  logic            done_q, done_d;
  logic            pending_q, pending_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            fall;

  // Open-drain: the slave only ever pulls low.
  assign port_io = drive_q ? 1'b0 : 1'bz;

  assign fall      = !bus_s_q && prev_q;
  assign ready_o   = !pending_q;
  assign drive_o   = drive_q;
  assign online_o  = online_q;
  assign done_o    = done_q;
  assign bit_cnt_o = bit_cnt_q;

  always_comb begin
    state_d   = state_q;
    lowcnt_d  = lowcnt_q;
    hcnt_d    = hcnt_q;
    tmr_d     = tmr_q;
    drive_d   = drive_q;
    online_d  = online_q;
    done_d    = 1'b0;
    pending_d = pending_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    bit_cnt_d = bit_cnt_q;

    case (state_q)
      StIdle: begin
        if (fall) begin
          state_d  = StLow;
          lowcnt_d = LowW'(1);
          if (online_q && pending_q) begin
            if (!shift_q[0]) begin
              drive_d = 1'b1;
              hcnt_d  = HoldW'(BIT_HOLD - 1);
            end
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              done_d = 1'b1;
`ifdef ONEWIRE_SLAVE_REPEAT_EN
              shift_d = hold_q;
`else
              pending_d = 1'b0;
`endif
            end
          end
        end
      end

      StLow: begin
        if (lowcnt_q < LowW'(RST_MIN)) begin
          lowcnt_d = lowcnt_q + 1'b1;
        end
        if (drive_q) begin
          if (hcnt_q == '0) begin
            drive_d = 1'b0;
          end else begin
            hcnt_d = hcnt_q - 1'b1;
          end
        end
        // Our own pull-down keeps bus_s low, so wait for it to be released first.
        if (bus_s_q && !drive_q) begin
          if (lowcnt_q >= LowW'(RST_MIN)) begin
            state_d   = StPresWait;
            tmr_d     = TmrW'(PRES_DLY - 1);
            online_d  = 1'b0;
            bit_cnt_d = 3'd0;
            shift_d   = hold_q;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StPresWait: begin
        if (tmr_q == '0) begin
          state_d = StPres;
          drive_d = 1'b1;
          tmr_d   = TmrW'(PRES_LEN - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      StPres: begin
        if (tmr_q == '0) begin
          state_d  = StWaitHigh;
          drive_d  = 1'b0;
          online_d = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      StWaitHigh: begin
        if (bus_s_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        drive_d = 1'b0;
      end
    endcase

    // pending_q is never set while a slot can consume, so no conflict with the shift above.
    if (load_i && !pending_q) begin
      shift_d   = data_in_i;
      hold_d    = data_in_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      sync1_q   <= 1'b1;
      bus_s_q   <= 1'b1;
      prev_q    <= 1'b1;
      lowcnt_q  <= '0;
      hcnt_q    <= '0;
      tmr_q     <= '0;
      drive_q   <= 1'b0;
      online_q  <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
      shift_q   <= 8'h00;
      hold_q    <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= port_io;
      bus_s_q   <= sync1_q;
      prev_q    <= bus_s_q;
      lowcnt_q  <= lowcnt_d;
      hcnt_q    <= hcnt_d;
      tmr_q     <= tmr_d;
      drive_q   <= drive_d;
      online_q  <= online_d;
      done_q    <= done_d;
      pending_q <= pending_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_onewire_slave.sv
// Bench for onewire_slave: bus master model plus a queue of expected slot bits.
module tb_onewire_slave;

`ifdef ONEWIRE_SLAVE_REPEAT_EN
  localparam bit RepeatEn = 1'b1;
`else
  localparam bit RepeatEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       master_low = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data_in = 8'h00;
  wire        bus;
  logic       ready, drive, online, done;
  logic [2:0] bit_cnt;

  pullup (bus);
  assign bus = master_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  onewire_slave dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .port_io  (bus),
    .data_in_i(data_in),
    .load_i   (load),
    .ready_o  (ready),
    .drive_o  (drive),
    .online_o (online),
    .done_o   (done),
    .bit_cnt_o(bit_cnt)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_seen = 0;
  int         exp_done = 0;
  bit         exp_bits[$];
  logic [7:0] cur_byte = 8'h00;
  bit         model_pend = 1'b0;
  bit         model_online = 1'b0;

  always @(negedge clk) if (rst_n && done) done_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
  endtask

  task automatic load_byte(input logic [7:0] b);
    data_in = b;
    load = 1'b1;
    tick();
    load = 1'b0;
    if (!model_pend) begin
      model_pend = 1'b1;
      cur_byte = b;
      push_byte(b);
    end
    check_eq("ready_after_load", ready, 0);
  endtask

  task automatic slot(input string tag);
    logic got;
    bit   exp;
    master_low = 1'b1;
    repeat (4) tick();
    master_low = 1'b0;
    repeat (2) tick();
    got = bus;
    exp = 1'b1;
    if (model_online && model_pend && exp_bits.size() > 0) begin
      exp = exp_bits.pop_front();
      if (exp_bits.size() == 0) begin
        exp_done++;
        if (RepeatEn) push_byte(cur_byte);
        else model_pend = 1'b0;
      end
    end
    check_eq(tag, got, exp);
    repeat (14) tick();
  endtask

  task automatic reset_pulse(input int len);
    int n;
    master_low = 1'b1;
    repeat (len) tick();
    master_low = 1'b0;
    model_online = 1'b0;
    exp_bits.delete();
    if (model_pend) push_byte(cur_byte);
    n = 0;
    while (!drive && n < 40) begin
      tick();
      n++;
    end
    check_eq("pres_delay", n, 5);
    check_eq("online_in_pres", online, 0);
    n = 0;
    while (drive && n < 60) begin
      tick();
      n++;
    end
    check_eq("pres_len", n, 24);
    check_eq("online_after_pres", online, 1);
    check_eq("bitcnt_after_pres", bit_cnt, 0);
    model_online = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit drv_seen;
    repeat (3) tick();
    check_eq("rst_drive", drive, 0);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_online", online, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_bitcnt", bit_cnt, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("idle_line", bus, 1);

    // Short low while offline must be ignored.
    drv_seen = 1'b0;
    master_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      drv_seen |= drive;
    end
    master_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      drv_seen |= drive;
    end
    check_eq("short_low_drive", drv_seen, 0);
    check_eq("short_low_online", online, 0);

    reset_pulse(50);

`ifdef ONEWIRE_SLAVE_REPEAT_EN
    load_byte(8'h81);
    load_byte(8'h3C);
    for (int i = 0; i < 16; i++) slot($sformatf("rep_slot%0d", i));
    check_eq("rep_done_cnt", done_seen, exp_done);
    check_eq("rep_ready", ready, 0);
    check_eq("rep_bitcnt", bit_cnt, 0);
    slot("rep_pre_rst0");
    reset_pulse(50);
    for (int i = 0; i < 3; i++) slot($sformatf("rep_post_rst%0d", i));
    check_eq("rep_ready_final", ready, 0);
`else
    load_byte(8'hA5);
    slot("a5_slot0");
    slot("a5_slot1");
    load_byte(8'h3C);
    for (int i = 2; i < 8; i++) slot($sformatf("a5_slot%0d", i));
    check_eq("a5_done_cnt", done_seen, exp_done);
    check_eq("a5_ready", ready, 1);
    check_eq("a5_bitcnt", bit_cnt, 0);

    slot("empty_slot");
    check_eq("empty_bitcnt", bit_cnt, 0);

    load_byte(8'h0F);
    for (int i = 0; i < 3; i++) slot($sformatf("0f_pre%0d", i));
    check_eq("0f_bitcnt_mid", bit_cnt, 3);
    reset_pulse(50);
    for (int i = 0; i < 8; i++) slot($sformatf("0f_post%0d", i));
    check_eq("0f_done_cnt", done_seen, exp_done);
    check_eq("0f_ready", ready, 1);
    check_eq("0f_bitcnt", bit_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onewire_slave.md
# onewire_slave

Cycle-accurate 1-wire slave endpoint that sits on the far side of the shared open-drain `port` line from the bus master. It detects master reset pulses and answers with a presence pulse. After that it serves master-initiated read slots, returning one bit of a locally loaded byte per slot, LSB first. It is the bus-level partner for master bring-up and regression, and the front end for any on-chip slave function.

## Interface
- `RST_MIN`, 32: minimum sampled-low run length, in cycles, classified as a bus reset. Must exceed `BIT_HOLD` + 2.
- `PRES_DLY`, 2: cycles from the end of a reset pulse (bus seen high) to the start of the presence pulse.
- `PRES_LEN`, 24: presence pulse length in cycles.
- `BIT_HOLD`, 8: cycles the slave holds the line low for a 0 bit, counted from slot detection.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `port`  inout  1  1-wire line. Driven 0 when `drive`=1, otherwise `1'bz`. Never driven 1.
- `data_in`  in  8  byte to transmit.
- `load`  in  1  captures `data_in` when `ready`=1; ignored otherwise.
- `ready`  out  1  no byte pending; can accept `load`.
- `drive`  out  1  slave is pulling the line low.
- `online`  out  1  presence has been sent since the last reset pulse or `reset`.
- `done`  out  1  one-cycle pulse after the 8th bit is issued.
- `bit_cnt`  out  3  index of the next bit to send.

## Operation
- Input path: `port` passes through a 2-flop synchronizer (`bus_s`), then a 1-flop edge register. Falling edge = `bus_s`=0 and previous=1.
- States:
  - IDLE: on a falling edge, go to LOW. Clear `lowcnt` to 1.
  - LOW: `lowcnt` increments each cycle and saturates at `RST_MIN`.
    - On entry, if `online`=1, a byte is pending and the current bit is 0, assert `drive` for `BIT_HOLD` cycles.
    - On entry, if `online`=1 and a byte is pending, the current bit is consumed whatever its value: shift right, `bit_cnt`+1.
    - Exit only when `bus_s`=1 and `drive`=0. If `lowcnt`≥`RST_MIN`, go to PRES_WAIT; else go to IDLE.
  - PRES_WAIT: count `PRES_DLY` cycles, then go to PRES.
  - PRES: `drive`=1 for `PRES_LEN` cycles. Bus activity is ignored. Set `online`=1 and go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE once `bus_s`=1.
- Byte handling:
  - A `load` accepted while `ready`=1 loads the shift register and the `hold` copy, and sets pending (`ready`=0).
  - After the 8th consumed bit (`bit_cnt` wraps 7→0), `done` pulses and pending clears (see Configuration).
  - With no byte pending, slots are not driven and the master reads 1s.
- Reset pulse detected (entry to PRES_WAIT), including mid-byte:
  - `online`=0 until presence completes.
  - `bit_cnt`=0.
  - Shift register reloaded from `hold`. The pending flag is unchanged.
- A reset pulse that arrives while the slave is offline is still answered with presence. Short lows while offline are ignored.
- `load` and slot consumption in the same cycle: `load` is ignored, since `ready`=0 while a byte is pending.

## Timing
- Reset values:
  - `drive`=0, `ready`=1, `online`=0, `done`=0, `bit_cnt`=0.
  - State IDLE, synchronizer flops=1, shift register and `hold`=0.
- Falling edge on `port` to `drive`=1: 3 clk (2 sync + edge register). `drive` then stays high for exactly `BIT_HOLD` cycles.
- End of reset low (`port` high) to `drive`=1: 3 + `PRES_DLY` cycles.
- `done` is asserted the cycle after the 8th bit is consumed.
- `ready` rises in the same cycle as `done`.
- `load` to `ready`=0: 1 cycle.

## Configuration
- `ONEWIRE_SLAVE_REPEAT_EN`:
  - Defined: after the 8th bit, the shift register reloads from `hold`, pending stays set, `ready` stays 0, and `done` still pulses. The byte repeats until the next `reset`. Reset pulses do not clear pending.
  - Undefined: pending clears after the 8th bit and `ready`=1.

## Test plan
- Master holds `port` low 50 cycles, then releases -> `drive` rises 5 cycles after release, lasts 24 cycles, then `online`=1.
- `online`, `load` 0xA5, 8 slots each 4 cycles low -> master samples 1,0,1,0,0,1,0,1. `done` pulses once, `ready`=1, `bit_cnt`=0.
- Offline, 10-cycle low pulse -> `drive` stays 0 and state returns to IDLE.
- 0x0F loaded, 3 slots served, then a 50-cycle low -> presence issued, `bit_cnt`=0, next slots read 1,1,1,1,0,0,0,0.
- `load` 0x3C asserted while 0xA5 is pending -> ignored, and 0xA5 is transmitted.
- With `ONEWIRE_SLAVE_REPEAT_EN`, `load` 0x81, 16 slots -> 0x81 read twice, `done` pulses twice, `ready` stays 0.
